// File: rtl/chu_vga_sprite_pkg.sv
// Package: chu_vga_sprite_pkg
// Purpose: shared address-map constants, per-sprite register record and a
//          field-width helper for the multi-sprite video core.
// Contents:
//   REGION_*      upper address bits selecting global / sprite registers
//   G_*, S_*      register indices inside each region
//   FRAME_MAX_W   storage width of a sprite frame number (N_FRAME <= 16)
//   spr_regs_t    x0, y0, en, anim_en, frame of one sprite
//   clog2_min1()  log2 that never returns 0, so a 1-entry field keeps a bit
package chu_vga_sprite_pkg;

  localparam logic [1:0] REGION_GLOBAL = 2'b10;
  localparam logic [1:0] REGION_SPRITE = 2'b11;

  localparam logic [1:0] G_BYPASS = 2'd0;
  localparam logic [1:0] G_KEY    = 2'd1;
  localparam logic [1:0] G_PERIOD = 2'd2;

  localparam logic [2:0] S_X0    = 3'd0;
  localparam logic [2:0] S_Y0    = 3'd1;
  localparam logic [2:0] S_CTRL  = 3'd2;
  localparam logic [2:0] S_FRAME = 3'd3;

  localparam int FRAME_MAX_W = 4;

  typedef struct packed {
    logic [10:0]            x0;
    logic [10:0]            y0;
    logic                   en;
    logic                   anim_en;
    logic [FRAME_MAX_W-1:0] frame;
  } spr_regs_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/chu_vga_multi_sprite_core_ram.sv
// Module: sprite_frame_ram
// Purpose: one-write / one-read synchronous RAM holding all animation frames
//          of a single sprite. Read is registered and read-first: a write and
//          a read of the same word in one cycle return the old contents.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write word address
//   i_wdata  write pixel
//   i_raddr  read word address (sampled every clock)
//   o_rdata  registered read pixel
module sprite_frame_ram #(
  parameter int CD    = 12,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [CD-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [CD-1:0] o_rdata
);

  logic [CD-1:0] r_mem [DEPTH];
  logic [CD-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/chu_vga_multi_sprite_core.sv
// Module: chu_vga_multi_sprite_core
// Purpose: overlays N_SPRITE animated sprites on the upstream pixel stream
//          with a fixed-priority chroma-key merge. Latency is 2 clocks.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   x, y           current pixel position from the frame counter
//   cs, write      slot chip select and write strobe
//   addr, wr_data  slot word address and write data (write-only bus)
//   si_rgb         upstream pixel
//   so_rgb         merged pixel, registered
module chu_vga_multi_sprite_core
  import chu_vga_sprite_pkg::*;
#(
  parameter int CD        = 12,
  parameter int N_SPRITE  = 4,
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int N_FRAME   = 2,
  parameter int KEY_COLOR = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int XW     = $clog2(SPR_W);
  localparam int YW     = $clog2(SPR_H);
  localparam int LOG_NF = $clog2(N_FRAME);
  localparam int FRW    = clog2_min1(N_FRAME);
  localparam int AW     = FRW + YW + XW;        // read-address width
  localparam int LOC_W  = LOG_NF + YW + XW;     // per-sprite span in the bus address
  localparam int DEPTH  = N_FRAME * SPR_W * SPR_H;
  localparam logic [31:0] TOTAL_WORDS = 32'(N_SPRITE * DEPTH);
  localparam logic [FRAME_MAX_W-1:0] FRAME_MASK = FRAME_MAX_W'(N_FRAME - 1);

  // ---------------- bus decode ----------------
  logic        w_wr_en, w_ram_wr, w_greg_wr, w_sreg_wr;
  logic [12:0] w_wsprite;
  logic [AW-1:0] w_waddr;

  assign w_wr_en   = cs & write;
  assign w_ram_wr  = w_wr_en & ~addr[13] & ({19'd0, addr[12:0]} < TOTAL_WORDS);
  assign w_greg_wr = w_wr_en & (addr[13:12] == REGION_GLOBAL);
  assign w_sreg_wr = w_wr_en & (addr[13:12] == REGION_SPRITE);
  assign w_wsprite = addr[12:0] >> LOC_W;
  assign w_waddr   = AW'(addr[LOC_W-1:0]);

  // ---------------- global registers and animation sequencer ----------------
  logic          r_bypass, r_at00;
  logic [CD-1:0] r_key;
  logic [7:0]    r_period, r_cnt;
  logic          w_tick, w_advance;

  // Rising edge of (0,0) so a held origin produces only one tick.
  assign w_tick    = (x == 11'd0) & (y == 11'd0) & ~r_at00;
  assign w_advance = w_tick & (r_period != 8'd0) & (r_cnt == r_period - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bypass <= 1'b0;
      r_key    <= CD'(KEY_COLOR);
      r_period <= 8'd0;
      r_cnt    <= 8'd0;
      r_at00   <= 1'b0;
    end else begin
      r_at00 <= (x == 11'd0) & (y == 11'd0);
      if (w_greg_wr && addr[1:0] == G_PERIOD) begin
        r_period <= wr_data[7:0];
        r_cnt    <= 8'd0;
      end else if (w_tick && r_period != 8'd0) begin
        r_cnt <= w_advance ? 8'd0 : r_cnt + 8'd1;
      end
      if (w_greg_wr && addr[1:0] == G_BYPASS) r_bypass <= wr_data[0];
      if (w_greg_wr && addr[1:0] == G_KEY)    r_key    <= wr_data[CD-1:0];
    end
  end

  // ---------------- per-sprite registers, hit test and RAM ----------------
  logic [N_SPRITE-1:0] w_cand;
  logic [CD-1:0]       w_pix [N_SPRITE];
  logic [N_SPRITE-1:0] w_frame_sink;

  genvar gi;
  generate
    for (gi = 0; gi < N_SPRITE; gi++) begin : gen_spr
      spr_regs_t     r_regs;
      logic          r_hit;
      logic          w_sel, w_hit, w_we;
      logic [11:0]   w_dx, w_dy;
      logic [AW-1:0] w_raddr;
      logic [CD-1:0] w_rd;

      assign w_sel = w_sreg_wr & (addr[7:4] == 4'(gi));
      assign w_we  = w_ram_wr & (w_wsprite == 13'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_regs <= '0;
          r_hit  <= 1'b0;
        end else begin
          r_hit <= w_hit;
          if (w_advance && r_regs.anim_en)
            r_regs.frame <= (r_regs.frame + FRAME_MAX_W'(1)) & FRAME_MASK;
          // Bus writes come last so a frame write beats a same-cycle advance.
          if (w_sel) begin
            case (addr[2:0])
              S_X0:    r_regs.x0 <= wr_data[10:0];
              S_Y0:    r_regs.y0 <= wr_data[10:0];
              S_CTRL:  begin
                r_regs.en      <= wr_data[0];
                r_regs.anim_en <= wr_data[1];
              end
              S_FRAME: r_regs.frame <= wr_data[FRAME_MAX_W-1:0] & FRAME_MASK;
              default: ;
            endcase
          end
        end
      end

      // 12-bit subtraction: bit 11 is the borrow, so positions left of or
      // above the origin never alias into the sprite window.
      assign w_dx  = {1'b0, x} - {1'b0, r_regs.x0};
      assign w_dy  = {1'b0, y} - {1'b0, r_regs.y0};
      assign w_hit = r_regs.en & ~w_dx[11] & ~w_dy[11] &
                     (w_dx < 12'(SPR_W)) & (w_dy < 12'(SPR_H));
      assign w_raddr = {r_regs.frame[FRW-1:0], w_dy[YW-1:0], w_dx[XW-1:0]};

      sprite_frame_ram #(.CD(CD), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (wr_data[CD-1:0]),
        .i_raddr (w_raddr),
        .o_rdata (w_rd)
      );

      assign w_cand[gi]       = r_hit & (w_rd != r_key);
      assign w_pix[gi]        = w_rd;
      assign w_frame_sink[gi] = ^r_regs.frame;
    end
  endgenerate

  // ---------------- stage 1 delay and stage 2 merge ----------------
  logic [CD-1:0] r_si_d1, r_so, w_win_pix;
  logic          w_any;

  // Scan from the highest index down so the lowest index wins.
  always_comb begin
    w_any     = 1'b0;
    w_win_pix = '0;
    for (int i = N_SPRITE - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_any     = 1'b1;
        w_win_pix = w_pix[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_si_d1 <= '0;
      r_so    <= '0;
    end else begin
      r_si_d1 <= si_rgb;
      r_so    <= (r_bypass | ~w_any) ? r_si_d1 : w_win_pix;
    end
  end

  assign so_rgb = r_so;

  // Bits of the write bus and frame record not used by every configuration.
  logic w_unused;
  assign w_unused = ^{wr_data, w_frame_sink};

endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
module tb_chu_vga_multi_sprite_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb;
  logic [11:0] so_rgb;

  int n_pass  = 0;
  int n_total = 0;

  chu_vga_multi_sprite_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ram_a(input int s, input int f, input int r, input int c);
    return 14'((s << 11) | (f << 10) | (r << 5) | c);
  endfunction
  function automatic logic [13:0] sreg_a(input int s, input int idx);
    return 14'(32'h3000 | (s << 4) | idx);
  endfunction
  function automatic logic [13:0] greg_a(input int idx);
    return 14'(32'h2000 | idx);
  endfunction

  // All stimulus tasks start and end at posedge + 1.
  task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic fill(input int s, input int f, input logic [11:0] c);
    for (int r = 0; r < 32; r++)
      for (int col = 0; col < 32; col++) begin
        cs = 1'b1; write = 1'b1; addr = ram_a(s, f, r, col); wr_data = {20'd0, c};
        @(posedge clk); #1;
      end
    cs = 1'b0; write = 1'b0;
    $display("fill sprite %0d frame %0d with %h", s, f, c);
  endtask

  // Holds a pixel position for the full 2-clock latency.
  task automatic drive_px(input int xv, input int yv, input logic [11:0] si);
    x = 11'(xv); y = 11'(yv); si_rgb = si;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic frame_tick();
    x = 11'd0; y = 11'd0;
    @(posedge clk); #1;
    x = 11'd1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; x = 11'd5; y = 11'd5; si_rgb = 12'hABC;
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk); #1;
    n_total++;
    if (so_rgb !== 12'h000) $display("FAIL reset_so: got %h want %h", so_rgb, 12'h000);
    else n_pass++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (so_rgb !== 12'h000) $display("FAIL first_clk: got %h want %h", so_rgb, 12'h000);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (so_rgb !== 12'hABC) $display("FAIL latency2: got %h want %h", so_rgb, 12'hABC);
    else n_pass++;
    drive_px(200, 200, 12'hABC);
    n_total++;
    if (so_rgb !== 12'hABC) $display("FAIL idle_pass: got %h want %h", so_rgb, 12'hABC);
    else n_pass++;
    $display("reset: so_rgb=%h", so_rgb);
  endtask

  task automatic test_window();
    int xv;
    logic [11:0] exp;
    int          ys   [4] = '{49, 50, 81, 82};
    logic [11:0] yexp [4] = '{12'h5A5, 12'hF00, 12'hF00, 12'h5A5};
    bus_wr(sreg_a(0, 0), 32'd100);
    bus_wr(sreg_a(0, 1), 32'd50);
    bus_wr(greg_a(1), 32'h0);
    fill(0, 0, 12'hF00);
    bus_wr(sreg_a(0, 2), 32'h1);
    // Streamed row: check each output against the pixel driven 2 clocks before.
    for (int i = 0; i < 40; i++) begin
      if (i >= 2) begin
        xv  = 96 + i - 2;
        exp = (xv >= 100 && xv <= 131) ? 12'hF00 : 12'h5A5;
        n_total++;
        if (so_rgb !== exp) $display("FAIL row x=%0d: got %h want %h", xv, so_rgb, exp);
        else n_pass++;
      end
      x = 11'(96 + i); y = 11'd50; si_rgb = 12'h5A5;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      drive_px(131, ys[i], 12'h5A5);
      n_total++;
      if (so_rgb !== yexp[i]) $display("FAIL col y=%0d: got %h want %h", ys[i], so_rgb, yexp[i]);
      else n_pass++;
    end
    $display("window: done");
  endtask

  task automatic test_overlap();
    fill(0, 0, 12'h0F0);
    fill(1, 0, 12'h00F);
    bus_wr(sreg_a(1, 0), 32'd100);
    bus_wr(sreg_a(1, 1), 32'd50);
    bus_wr(sreg_a(1, 2), 32'h1);
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h0F0) $display("FAIL prio: got %h want %h", so_rgb, 12'h0F0);
    else n_pass++;
    fill(0, 0, 12'h000);
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h00F) $display("FAIL keyed: got %h want %h", so_rgb, 12'h00F);
    else n_pass++;
    bus_wr(sreg_a(1, 2), 32'h0);
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h5A5) $display("FAIL all_keyed: got %h want %h", so_rgb, 12'h5A5);
    else n_pass++;
    $display("overlap: done");
  endtask

  task automatic test_animation();
    logic [11:0] exp [6] = '{12'h111, 12'h111, 12'h222, 12'h222, 12'h222, 12'h111};
    fill(0, 0, 12'h111);
    fill(0, 1, 12'h222);
    bus_wr(sreg_a(0, 3), 32'h0);
    bus_wr(greg_a(2), 32'd3);
    bus_wr(sreg_a(0, 2), 32'h3);
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h111) $display("FAIL anim_start: got %h want %h", so_rgb, 12'h111);
    else n_pass++;
    for (int t = 0; t < 6; t++) begin
      frame_tick();
      drive_px(110, 60, 12'h5A5);
      n_total++;
      if (so_rgb !== exp[t]) $display("FAIL anim tick %0d: got %h want %h", t + 1, so_rgb, exp[t]);
      else n_pass++;
    end
    bus_wr(greg_a(2), 32'd0);
    for (int t = 0; t < 3; t++) begin
      frame_tick();
      drive_px(110, 60, 12'h5A5);
      n_total++;
      if (so_rgb !== 12'h111) $display("FAIL frozen tick %0d: got %h want %h", t + 1, so_rgb, 12'h111);
      else n_pass++;
    end
    $display("animation: done");
  endtask

  task automatic test_collision();
    bus_wr(greg_a(2), 32'd1);
    frame_tick();
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h222) $display("FAIL pre_adv: got %h want %h", so_rgb, 12'h222);
    else n_pass++;
    // Tick and frame write land on the same edge; the advance alone would give 0.
    x = 11'd0; y = 11'd0;
    cs = 1'b1; write = 1'b1; addr = sreg_a(0, 3); wr_data = 32'h1;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; x = 11'd1;
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h222) $display("FAIL write_wins: got %h want %h", so_rgb, 12'h222);
    else n_pass++;
    frame_tick();
    drive_px(110, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h111) $display("FAIL post_adv: got %h want %h", so_rgb, 12'h111);
    else n_pass++;
    bus_wr(sreg_a(0, 2), 32'h1);
    $display("collision: done");
  endtask

  task automatic test_clipping();
    int          xs   [6] = '{2039, 2040, 2047, 0, 7, 23};
    logic [11:0] xexp [6] = '{12'h5A5, 12'h111, 12'h111, 12'h5A5, 12'h5A5, 12'h5A5};
    bus_wr(sreg_a(0, 0), 32'd2040);
    bus_wr(sreg_a(0, 3), 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive_px(xs[i], 60, 12'h5A5);
      n_total++;
      if (so_rgb !== xexp[i]) $display("FAIL clip x=%0d: got %h want %h", xs[i], so_rgb, xexp[i]);
      else n_pass++;
    end
    bus_wr(greg_a(0), 32'h1);
    drive_px(2044, 60, 12'h3C3);
    n_total++;
    if (so_rgb !== 12'h3C3) $display("FAIL bypass_on: got %h want %h", so_rgb, 12'h3C3);
    else n_pass++;
    bus_wr(greg_a(0), 32'h0);
    drive_px(2044, 60, 12'h3C3);
    n_total++;
    if (so_rgb !== 12'h111) $display("FAIL bypass_off: got %h want %h", so_rgb, 12'h111);
    else n_pass++;
    bus_wr(greg_a(0), 32'h1);
    $display("clipping/bypass: done");
  endtask

  task automatic test_reset_mid();
    drive_px(2044, 60, 12'h5A5);
    n_total++;
    if (so_rgb !== 12'h5A5) $display("FAIL pre_reset: got %h want %h", so_rgb, 12'h5A5);
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_total++;
    if (so_rgb !== 12'h000) $display("FAIL async_reset: got %h want %h", so_rgb, 12'h000);
    else n_pass++;
    @(posedge clk); #1;
    x = 11'd2044; y = 11'd60; si_rgb = 12'h123;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (so_rgb !== 12'h000) $display("FAIL rel_clk1: got %h want %h", so_rgb, 12'h000);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (so_rgb !== 12'h123) $display("FAIL rel_clk2: got %h want %h", so_rgb, 12'h123);
    else n_pass++;
    $display("reset_mid: so_rgb=%h", so_rgb);
  endtask

  initial begin
    test_reset();
    test_window();
    test_overlap();
    test_animation();
    test_collision();
    test_clipping();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
